// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the quad-core shared memory bus.
// Grants one core at a time for exactly one memory transaction. The transaction
// ends on mem_ready, or is aborted by a watchdog if memory does not answer within
// TIMEOUT cycles. An optional one-cycle turnaround separates successive grants.
// Every output comes straight from a register.
module bus_arbiter_rr #(
  parameter int TIMEOUT    = 16,  // max cycles a grant waits for mem_ready (>= 2)
  parameter int TURNAROUND = 1    // 1: idle cycle between grants, 0: back-to-back
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic [3:0] done,
  output logic       timeout_err
);

  // Timer width covers TIMEOUT-1 with headroom, so it saturates instead of wrapping.
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic [3:0]    done_q, done_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    last_q, last_d;

  // Winner search: last+1 has highest priority, last itself the lowest.
  // Iterating from lowest to highest priority lets the highest overwrite the rest.
  // Callers only use the result when r is non-zero.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    win = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  // Winner among the current requests, measured from the core that was served last.
  logic [1:0] idle_winner;
  // Winner when re-arbitrating on completion: the finishing core becomes "last".
  logic [1:0] chain_winner;

  // Both winners are pure functions of inputs and registered state.
  always_comb begin
    idle_winner  = pick_winner(req, last_q);
    chain_winner = pick_winner(req, gnt_id_q);
  end

  // Next-state and next-output logic for the IDLE / BUSY / TURN controller.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    gnt_id_d      = gnt_id_q;
    busy_d        = busy_q;
    done_d        = 4'b0000;
    timeout_err_d = 1'b0;
    timer_d       = timer_q;
    last_d        = last_q;

    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          grant_d  = 4'b0001 << idle_winner;
          gnt_id_d = idle_winner;
          busy_d   = 1'b1;
          timer_d  = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        // Request changes are ignored while a transaction is in flight.
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;

        if (mem_ready) begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          done_d = grant_q;
          last_d = gnt_id_q;
          if (TURNAROUND == 0 && req != 4'b0000) begin
            grant_d  = 4'b0001 << chain_winner;
            gnt_id_d = chain_winner;
            busy_d   = 1'b1;
            timer_d  = '0;
            state_d  = BUSY;
          end else begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            state_d = (TURNAROUND != 0) ? TURN : IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Watchdog abort: the core loses its slot and goes to the back of the rotation.
          timeout_err_d = 1'b1;
          last_d        = gnt_id_q;
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
          state_d       = (TURNAROUND != 0) ? TURN : IDLE;
        end
      end

      TURN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      gnt_id_q      <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 4'b0000;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
      last_q        <= 2'd3;  // core 0 wins the first arbitration
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the values present before the edge.
      state_q       <= state_d;
      grant_q       <= grant_d;
      gnt_id_q      <= gnt_id_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
    end
  end

  assign grant       = grant_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
